// File: rtl/obj_dma_pkg.sv
// Shared constants and types for the object-attribute DMA engine.
// The buffer address is {bank, offset}, with one bank bit and a 10-bit offset.
package obj_dma_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int BANK_W = 1;
  localparam int OFF_W  = 10;
  localparam int BUF_AW = BANK_W + OFF_W;

  localparam logic [ADDR_W-1:0] SRC_BASE_DEF = 13'h1500;
  // LEN must lie in 1..1024 so that every index fits in OFF_W bits.
  localparam int                LEN_DEF      = 768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // The source address wraps at 8K because the sum is truncated to ADDR_W bits.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [OFF_W-1:0]  idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/dpram.sv
// Simple dual-port RAM: port A writes, port B performs a registered read.
// Only the read register takes reset, so the read data comes out of reset at zero.
module dpram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] dout_b
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;

  // NOTE: the storage array takes no reset, so it maps onto block RAM. Only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[addr_b];
    end
  end

  assign dout_b = rd_q;

endmodule

// File: rtl/obj_dma.sv
// At each vblank, copies LEN bytes from screen RAM port A into the write bank of a double buffer.
// The display bank swaps when the copy completes.
module obj_dma
  import obj_dma_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SRC_BASE = SRC_BASE_DEF,
  parameter int                LEN      = LEN_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vb,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_en,
  input  logic [DATA_W-1:0] dma_data,
  input  logic              dma_wait,
  input  logic [OFF_W-1:0]  buf_rd_addr,
  output logic [DATA_W-1:0] buf_rd_data,
  output logic              busy,
  output logic              done
);

  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(LEN - 1);

  state_e             state_q, state_d;
  logic               vb_q;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic               issued_q, issued_d;
  logic [OFF_W-1:0]   issued_idx_q;
  logic               disp_bank_q, disp_bank_d;
  logic               done_q, done_d;
  logic               vb_rise;
  logic [BUF_AW-1:0]  wr_addr;
  logic [BUF_AW-1:0]  rd_addr;

  assign vb_rise = vb & ~vb_q;

  // NOTE: every signal gets its default before the case statement, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    disp_bank_d = disp_bank_q;
    done_d      = 1'b0;
    issued_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (vb_rise) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        issued_d = ~dma_wait;
        if (!dma_wait) begin
          if (cnt_q == LAST_IDX) begin
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        // The last byte lands this cycle; the swap and done go out on the same edge.
        state_d     = IDLE;
        disp_bank_d = ~disp_bank_q;
        done_d      = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: all state updates use non-blocking assignments, so every flop samples its pre-edge value.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      vb_q         <= 1'b0;
      cnt_q        <= '0;
      issued_q     <= 1'b0;
      issued_idx_q <= '0;
      disp_bank_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vb_q         <= vb;
      cnt_q        <= cnt_d;
      issued_q     <= issued_d;
      issued_idx_q <= cnt_q;
      disp_bank_q  <= disp_bank_d;
      done_q       <= done_d;
    end
  end

  assign dma_en   = (state_q == RUN);
  assign dma_addr = dma_en ? src_addr(SRC_BASE, cnt_q) : '0;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  // Outside the swap edge, the writer and the renderer always address opposite banks.
  assign wr_addr = {~disp_bank_q, issued_idx_q};
  assign rd_addr = {disp_bank_q, buf_rd_addr};

  dpram #(BUF_AW, DATA_W) u_buf (
    .clk    (clk_sys),
    .reset  (reset),
    .we_a   (issued_q),
    .addr_a (wr_addr),
    .din_a  (dma_data),
    .addr_b (rd_addr),
    .dout_b (buf_rd_data)
  );

endmodule

// File: tb/tb_obj_dma.sv
// Bench for obj_dma: a screen-RAM model, a double-buffer reference model and a table of frames.
// Two instances cover the default window and an 8K-wrapping window.
module tb_obj_dma;

  localparam int F_IDX = 0, F_AA = 1, F_55 = 2, F_RND = 3;
  localparam int W_NONE = 0, W_THIRD = 1, W_RND = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [1:0]  vb, dma_wait, dma_en, busy, done;
  logic [12:0] dma_addr    [2];
  logic [7:0]  dma_data    [2];
  logic [9:0]  buf_rd_addr [2];
  logic [7:0]  buf_rd_data [2];

  logic [7:0]  sram [8192];
  logic [7:0]  mb   [2][2][1024];
  bit          mv   [2][2][1024];
  bit          disp_m [2];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Registered screen RAM; a waited cycle returns junk, so a stray write would corrupt the buffer.
  always @(posedge clk_sys) begin
    dma_data[0] <= (dma_en[0] && !dma_wait[0]) ? sram[dma_addr[0]] : 8'hEE;
    dma_data[1] <= (dma_en[1] && !dma_wait[1]) ? sram[dma_addr[1]] : 8'hEE;
  end

  obj_dma u_dut0 (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .vb          (vb[0]),
    .dma_addr    (dma_addr[0]),
    .dma_en      (dma_en[0]),
    .dma_data    (dma_data[0]),
    .dma_wait    (dma_wait[0]),
    .buf_rd_addr (buf_rd_addr[0]),
    .buf_rd_data (buf_rd_data[0]),
    .busy        (busy[0]),
    .done        (done[0])
  );

  obj_dma #(.SRC_BASE(13'h1F00), .LEN(512)) u_dut1 (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .vb          (vb[1]),
    .dma_addr    (dma_addr[1]),
    .dma_en      (dma_en[1]),
    .dma_data    (dma_data[1]),
    .dma_wait    (dma_wait[1]),
    .buf_rd_addr (buf_rd_addr[1]),
    .buf_rd_data (buf_rd_data[1]),
    .busy        (busy[1]),
    .done        (done[1])
  );

  typedef struct {
    int          sel;
    int          fill;
    int          wmode;
    logic [12:0] exp_first;
    logic [12:0] exp_last;
    int          exp_base_dur;
    int          chk_addr;
    int          chk_data;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [12:0] base_of(input int sel);
    return (sel != 0) ? 13'h1F00 : 13'h1500;
  endfunction

  function automatic int len_of(input int sel);
    return (sel != 0) ? 512 : 768;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input int sel, input int kind);
    logic [12:0] a;
    for (int i = 0; i < len_of(sel); i++) begin
      a = base_of(sel) + 13'(i);
      case (kind)
        F_IDX:   sram[a] = 8'(i);
        F_AA:    sram[a] = 8'hAA;
        F_55:    sram[a] = 8'h55;
        default: sram[a] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // The byte for idx i comes from base+i, with the address wrapping at 8K.
  task automatic commit(input int sel, input int bank, input int nbytes);
    logic [12:0] a;
    for (int i = 0; i < nbytes; i++) begin
      a = base_of(sel) + 13'(i);
      mb[sel][bank][i] = sram[a];
      mv[sel][bank][i] = 1'b1;
    end
  endtask

  task automatic read_check(input int sel, input int addr, input int exp);
    @(posedge clk_sys); #1;
    buf_rd_addr[sel] = 10'(addr);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check($sformatf("rd_data[%0d][%0d]", sel, addr), 32'(buf_rd_data[sel]), 32'(exp));
  endtask

  task automatic run_frame(input int sel, input int wmode, input int rst_at,
                           input logic [12:0] exp_first, input logic [12:0] exp_last,
                           input int exp_base_dur);
    int          t0, rel, k, waits, dones, runs, first_en, done_rel, k_at_rst;
    int          addr_err, busy_err, rd_err, pa, pb, ra, len;
    logic [12:0] base, ea, first_a, last_a;
    bit          w, pend, exp_busy;
    len = len_of(sel);
    base = base_of(sel);
    k = 0; waits = 0; dones = 0; runs = 0; first_en = -1; done_rel = -1; k_at_rst = 0;
    addr_err = 0; busy_err = 0; rd_err = 0; pend = 1'b0; pa = 0; pb = 0;
    first_a = '0; last_a = '0;

    @(posedge clk_sys); #1;
    vb[sel] = 1'b1;
    dma_wait[sel] = 1'b0;
    @(negedge clk_sys);
    t0 = cyc;

    for (int c = 1; c <= 3000; c++) begin
      @(posedge clk_sys); #1;
      if (c == 100) vb[sel] = 1'b0;
      if (c == 101) vb[sel] = 1'b1;
      if (c == 200) vb[sel] = 1'b0;
      case (wmode)
        W_THIRD: w = ((runs + 1) % 3 == 0);
        W_RND:   w = ($urandom_range(0, 3) == 0);
        default: w = 1'b0;
      endcase
      dma_wait[sel] = w;
      reset = (c == rst_at);
      ra = $urandom_range(0, 1023);
      buf_rd_addr[sel] = 10'(ra);
      @(negedge clk_sys);
      rel = cyc - t0;

      if (rst_at > 0 && rel == rst_at + 1) begin
        check("rst_dma_en", 32'(dma_en[sel]), 32'd0);
        check("rst_busy", 32'(busy[sel]), 32'd0);
        check("rst_dma_addr", 32'(dma_addr[sel]), 32'd0);
        check("rst_rd_data", 32'(buf_rd_data[sel]), 32'd0);
        check("rst_disp_bank0", 32'(u_dut0.disp_bank_q), 32'd0);
        check("rst_disp_bank1", 32'(u_dut1.disp_bank_q), 32'd0);
        check("rst_bytes_before", 32'(k_at_rst), 32'(rst_at - 1));
        commit(sel, disp_m[sel] ? 0 : 1, k_at_rst);
        disp_m[0] = 1'b0;
        disp_m[1] = 1'b0;
        dma_wait[sel] = 1'b0;
        return;
      end
      if (rel == rst_at) k_at_rst = k;

      if (pend && mv[sel][pb][pa] && buf_rd_data[sel] !== mb[sel][pb][pa]) rd_err++;

      if (dma_en[sel]) begin
        runs++;
        if (first_en < 0) begin
          first_en = rel;
          first_a = dma_addr[sel];
        end
        ea = base + 13'(k);
        if (dma_addr[sel] !== ea) addr_err++;
        last_a = dma_addr[sel];
        if (w) waits++;
        else k++;
      end

      exp_busy = (rel < len + 2 + waits);
      if (busy[sel] !== exp_busy) busy_err++;

      if (done[sel]) begin
        dones++;
        if (done_rel < 0) begin
          done_rel = rel;
          commit(sel, disp_m[sel] ? 0 : 1, len);
          disp_m[sel] = ~disp_m[sel];
        end
      end

      pend = 1'b1;
      pa = ra;
      pb = disp_m[sel] ? 1 : 0;
      if (done_rel >= 0 && rel >= done_rel + 5) break;
    end

    dma_wait[sel] = 1'b0;
    if (done_rel < 0) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("addr_seq_err", 32'(addr_err), 32'd0);
      check("first_addr", 32'(first_a), 32'(exp_first));
      check("last_addr", 32'(last_a), 32'(exp_last));
      check("first_en_cycle", 32'(first_en), 32'd1);
      check("bytes_issued", 32'(k), 32'(len));
      check("duration", 32'(done_rel), 32'(exp_base_dur + waits));
      check("done_count", 32'(dones), 32'd1);
      check("busy_err", 32'(busy_err), 32'd0);
      check("rd_err", 32'(rd_err), 32'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 3000000", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, F_IDX, W_NONE,  13'h1500, 13'h17FF, 770,   5, 8'h05};
    vecs[1] = '{0, F_IDX, W_THIRD, 13'h1500, 13'h17FF, 770, 767, 8'hFF};
    vecs[2] = '{0, F_AA,  W_NONE,  13'h1500, 13'h17FF, 770, 100, 8'hAA};
    vecs[3] = '{0, F_55,  W_RND,   13'h1500, 13'h17FF, 770,   3, 8'h55};
    vecs[4] = '{0, F_RND, W_RND,   13'h1500, 13'h17FF, 770,  -1, 0};
    vecs[5] = '{1, F_IDX, W_NONE,  13'h1F00, 13'h00FF, 514, 511, 8'hFF};
    vecs[6] = '{1, F_RND, W_RND,   13'h1F00, 13'h00FF, 514,  -1, 0};

    reset = 1'b1;
    vb = 2'b00;
    dma_wait = 2'b00;
    buf_rd_addr[0] = '0;
    buf_rd_addr[1] = '0;
    disp_m[0] = 1'b0;
    disp_m[1] = 1'b0;

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_dma_en[%0d]", s), 32'(dma_en[s]), 32'd0);
      check($sformatf("reset_dma_addr[%0d]", s), 32'(dma_addr[s]), 32'd0);
      check($sformatf("reset_busy[%0d]", s), 32'(busy[s]), 32'd0);
      check($sformatf("reset_done[%0d]", s), 32'(done[s]), 32'd0);
      check($sformatf("reset_rd_data[%0d]", s), 32'(buf_rd_data[s]), 32'd0);
    end
    check("reset_disp_bank", 32'(u_dut0.disp_bank_q), 32'd0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);

    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].sel, vecs[v].fill);
      run_frame(vecs[v].sel, vecs[v].wmode, -1, vecs[v].exp_first, vecs[v].exp_last,
                vecs[v].exp_base_dur);
      if (vecs[v].chk_addr >= 0) read_check(vecs[v].sel, vecs[v].chk_addr, vecs[v].chk_data);
    end

    // Reset at RUN cycle 300; the next vblank has to start again from the base address.
    fill(0, F_RND);
    run_frame(0, W_NONE, 300, 13'h1500, 13'h17FF, 770);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk_sys);
    fill(0, F_IDX);
    run_frame(0, W_NONE, -1, 13'h1500, 13'h17FF, 770);
    read_check(0, 5, 8'h05);
    read_check(0, 700, 8'hBC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
